// File: rtl/victim_cache_pkg.sv
// Shared types for the victim-cache tag store: opcodes, flush FSM states and per-way entry.
// Tags are held zero-extended to TAG_W_MAX so the entry struct stays parameter-free.
package victim_cache_pkg;

    localparam int unsigned TAG_W_MAX = 32;

    typedef enum logic [2:0] {
        OP_LOOKUP      = 3'd0,
        OP_INSERT      = 3'd1,
        OP_INVALIDATE  = 3'd2,
        OP_SET_DIRTY   = 3'd3,
        OP_CLEAR_DIRTY = 3'd4,
        OP_READ        = 3'd5,
        OP_NOP6        = 3'd6,
        OP_NOP7        = 3'd7
    } tag_op_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FLUSH_SCAN = 2'd1,
        ST_FLUSH_WB   = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic [TAG_W_MAX-1:0] tag;
        logic                 valid;
        logic                 dirty;
    } way_entry_t;

endpackage

// File: rtl/lru_age_tracker.sv
// True-LRU age tracker: ages form a permutation of 0..NUM_WAYS-1, oldest way is the LRU.
// A touch zeroes the touched way's age and ages every younger way by one.
module lru_age_tracker #(
    parameter int unsigned  NUM_WAYS = 4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_touch,
    input  logic [WAY_W-1:0] i_touch_way,
    output logic [WAY_W-1:0] o_lru_way
);

    logic [WAY_W-1:0] r_age [NUM_WAYS];
    logic [WAY_W-1:0] w_lru_way;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_age[i] <= WAY_W'(i);
            end
        end else if (i_touch) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (WAY_W'(i) == i_touch_way) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < r_age[i_touch_way]) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_lru_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (r_age[i] == WAY_W'(NUM_WAYS - 1)) begin
                w_lru_way = WAY_W'(i);
            end
        end
    end

    assign o_lru_way = w_lru_way;

endmodule

// File: rtl/victim_tag_lru.sv
// Fully associative victim-cache tag store with LRU victim selection, swap-on-hit option
// and a handshaked dirty-line flush engine. One command per cycle, registered response.
module victim_tag_lru
    import victim_cache_pkg::*;
#(
    parameter int unsigned  TAG_WIDTH   = 4,
    parameter int unsigned  NUM_WAYS    = 4,
    parameter bit           SWAP_ON_HIT = 1'b1,
    localparam int unsigned WAY_W       = $clog2(NUM_WAYS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [2:0]           i_cmd_op,
    input  logic [TAG_WIDTH-1:0] i_cmd_tag,
    input  logic [WAY_W-1:0]     i_cmd_way,
    input  logic                 i_cmd_dirty,
    output logic                 o_rsp_valid,
    output logic                 o_rsp_hit,
    output logic [WAY_W-1:0]     o_rsp_way,
    output logic [TAG_WIDTH-1:0] o_rsp_tag,
    output logic                 o_rsp_vbit,
    output logic                 o_rsp_dirty,
    output logic                 o_rsp_evict,
    output logic [TAG_WIDTH-1:0] o_rsp_evict_tag,
    output logic                 o_rsp_evict_dirty,
    input  logic                 i_flush_req,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [TAG_WIDTH-1:0] o_wb_tag,
    output logic [WAY_W-1:0]     o_wb_way,
    output logic                 o_flush_done
);

    way_entry_t r_entry   [NUM_WAYS];
    way_entry_t w_entry_d [NUM_WAYS];

    fsm_state_e       r_state, w_state_d;
    logic [WAY_W-1:0] r_ptr, w_ptr_d;

    logic                 r_rsp_valid, r_rsp_hit, r_rsp_vbit, r_rsp_dirty;
    logic                 r_rsp_evict, r_rsp_evict_dirty;
    logic [WAY_W-1:0]     r_rsp_way;
    logic [TAG_WIDTH-1:0] r_rsp_tag, r_rsp_evict_tag;

    tag_op_e              w_op;
    logic [TAG_W_MAX-1:0] w_tag_ext;
    logic                 w_accept, w_hit, w_free, w_touch, w_flush_done, w_ptr_last;
    logic                 w_rsp_hit, w_evict;
    logic [WAY_W-1:0]     w_hit_way, w_free_way, w_lru_way, w_victim, w_touch_way, w_rsp_way;

    assign w_op        = tag_op_e'(i_cmd_op);
    assign w_tag_ext   = TAG_W_MAX'(i_cmd_tag);
    assign o_cmd_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_ptr_last  = (r_ptr == WAY_W'(NUM_WAYS - 1));

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (r_entry[i].valid && (r_entry[i].tag == w_tag_ext)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!r_entry[i].valid) begin
                w_free     = 1'b1;
                w_free_way = WAY_W'(i);
            end
        end
    end

    assign w_victim = w_free ? w_free_way : w_lru_way;

    lru_age_tracker #(
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_touch     (w_touch),
        .i_touch_way (w_touch_way),
        .o_lru_way   (w_lru_way)
    );

    always_comb begin
        w_entry_d    = r_entry;
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_touch      = 1'b0;
        w_touch_way  = '0;
        w_flush_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_LOOKUP: begin
                            if (w_hit) begin
                                if (SWAP_ON_HIT) begin
                                    w_entry_d[w_hit_way].valid = 1'b0;
                                    w_entry_d[w_hit_way].dirty = 1'b0;
                                end else begin
                                    w_touch     = 1'b1;
                                    w_touch_way = w_hit_way;
                                end
                            end
                        end
                        OP_INSERT: begin
                            w_touch = 1'b1;
                            if (w_hit) begin
                                w_entry_d[w_hit_way].dirty = r_entry[w_hit_way].dirty | i_cmd_dirty;
                                w_touch_way                = w_hit_way;
                            end else begin
                                w_entry_d[w_victim].tag   = w_tag_ext;
                                w_entry_d[w_victim].valid = 1'b1;
                                w_entry_d[w_victim].dirty = i_cmd_dirty;
                                w_touch_way               = w_victim;
                            end
                        end
                        OP_INVALIDATE: begin
                            w_entry_d[i_cmd_way].valid = 1'b0;
                            w_entry_d[i_cmd_way].dirty = 1'b0;
                        end
                        OP_SET_DIRTY: begin
                            if (r_entry[i_cmd_way].valid) begin
                                w_entry_d[i_cmd_way].dirty = 1'b1;
                            end
                        end
                        OP_CLEAR_DIRTY: w_entry_d[i_cmd_way].dirty = 1'b0;
                        default: ;
                    endcase
                end else if (i_flush_req && !i_cmd_valid) begin
                    w_state_d = ST_FLUSH_SCAN;
                    w_ptr_d   = '0;
                end
            end
            ST_FLUSH_SCAN: begin
                if (r_entry[r_ptr].valid && r_entry[r_ptr].dirty) begin
                    w_state_d = ST_FLUSH_WB;
                end else begin
                    w_entry_d[r_ptr].valid = 1'b0;
                    w_entry_d[r_ptr].dirty = 1'b0;
                    if (w_ptr_last) begin
                        w_state_d    = ST_IDLE;
                        w_flush_done = 1'b1;
                    end else begin
                        w_ptr_d = r_ptr + 1'b1;
                    end
                end
            end
            ST_FLUSH_WB: begin
                if (i_wb_ready) begin
                    w_entry_d[r_ptr].valid = 1'b0;
                    w_entry_d[r_ptr].dirty = 1'b0;
                    if (w_ptr_last) begin
                        w_state_d    = ST_IDLE;
                        w_flush_done = 1'b1;
                    end else begin
                        w_state_d = ST_FLUSH_SCAN;
                        w_ptr_d   = r_ptr + 1'b1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_entry <= w_entry_d;
        end
    end

    always_comb begin
        w_rsp_way = '0;
        w_rsp_hit = 1'b0;
        case (w_op)
            OP_LOOKUP: begin
                w_rsp_way = w_hit_way;
                w_rsp_hit = w_hit;
            end
            OP_INSERT: begin
                w_rsp_way = w_hit ? w_hit_way : w_victim;
                w_rsp_hit = w_hit;
            end
            OP_INVALIDATE, OP_SET_DIRTY, OP_CLEAR_DIRTY, OP_READ: w_rsp_way = i_cmd_way;
            default: ;
        endcase
    end

    assign w_evict = (w_op == OP_INSERT) && !w_hit && r_entry[w_victim].valid;

    // Response data only moves on an accepted command so it holds between pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid       <= 1'b0;
            r_rsp_hit         <= 1'b0;
            r_rsp_way         <= '0;
            r_rsp_tag         <= '0;
            r_rsp_vbit        <= 1'b0;
            r_rsp_dirty       <= 1'b0;
            r_rsp_evict       <= 1'b0;
            r_rsp_evict_tag   <= '0;
            r_rsp_evict_dirty <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_hit         <= w_rsp_hit;
                r_rsp_way         <= w_rsp_way;
                r_rsp_tag         <= r_entry[w_rsp_way].tag[TAG_WIDTH-1:0];
                r_rsp_vbit        <= r_entry[w_rsp_way].valid;
                r_rsp_dirty       <= r_entry[w_rsp_way].dirty;
                r_rsp_evict       <= w_evict;
                r_rsp_evict_tag   <= w_evict ? r_entry[w_victim].tag[TAG_WIDTH-1:0] : '0;
                r_rsp_evict_dirty <= w_evict && r_entry[w_victim].dirty;
            end
        end
    end

    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_hit         = r_rsp_hit;
    assign o_rsp_way         = r_rsp_way;
    assign o_rsp_tag         = r_rsp_tag;
    assign o_rsp_vbit        = r_rsp_vbit;
    assign o_rsp_dirty       = r_rsp_dirty;
    assign o_rsp_evict       = r_rsp_evict;
    assign o_rsp_evict_tag   = r_rsp_evict_tag;
    assign o_rsp_evict_dirty = r_rsp_evict_dirty;

    assign o_wb_valid   = (r_state == ST_FLUSH_WB);
    assign o_wb_tag     = o_wb_valid ? r_entry[r_ptr].tag[TAG_WIDTH-1:0] : '0;
    assign o_wb_way     = o_wb_valid ? r_ptr : '0;
    assign o_flush_done = w_flush_done && !i_rst;

endmodule
